// File: rtl/cpu_clk_pkg.sv
// Shared types and defaults for the CPU clock-enable controller.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    HALT,
    RUN,
    STEP
  } clk_state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-count debouncer and a
// one-cycle press pulse on the debounced rising edge only.
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_prev_q;
  logic [CW-1:0] cnt_q;

  // The counter only advances while the synchronized level disagrees with the
  // accepted level, so any bounce back to the old level restarts the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Turns the slow divider tick into a single-cycle CPU clock enable, with
// RUN / HALT / single-STEP control from two buttons and the CPU's HLT request.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic        START_RUNNING   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       halt_req,
  output logic       cpu_en,
  output logic       running,
  output logic [7:0] en_count
);

  clk_state_t state_q;
  logic       tick_q;
  logic       cpu_en_q;
  logic [7:0] en_count_q;
  logic       tick_rise;
  logic       run_p;
  logic       step_p;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_run),
    .press  (run_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_step),
    .press  (step_p)
  );

  assign tick_rise = tick & ~tick_q;

  // cpu_en defaults low every cycle, so it can only ever be a one-cycle pulse;
  // halt_req outranks everything in RUN so a HLT never gets one extra step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= START_RUNNING ? RUN : HALT;
      tick_q     <= 1'b0;
      cpu_en_q   <= 1'b0;
      en_count_q <= 8'd0;
    end else begin
      tick_q   <= tick;
      cpu_en_q <= 1'b0;
      if (cpu_en_q) begin
        en_count_q <= en_count_q + 8'd1;
      end
      case (state_q)
        HALT: begin
          if (run_p) begin
            state_q <= RUN;
          end else if (step_p) begin
            state_q  <= STEP;
            cpu_en_q <= 1'b1;
          end
        end
        RUN: begin
          if (halt_req) begin
            state_q <= HALT;
          end else if (run_p) begin
            state_q <= HALT;
          end else if (tick_rise) begin
            cpu_en_q <= 1'b1;
          end
        end
        STEP: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  assign cpu_en   = cpu_en_q;
  assign running  = (state_q == RUN);
  assign en_count = en_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: stimulus queues the cycle each cpu_en
// pulse must appear in, and a negedge monitor pops and compares every pulse.
module tb_cpu_clk_ctrl;

  localparam int DC        = 4;
  localparam int PRESS_LAT = 2 + DC + 1;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       tick     = 1'b0;
  logic       btn_run  = 1'b0;
  logic       btn_step = 1'b0;
  logic       halt_req = 1'b0;
  logic       cpu_en;
  logic       running;
  logic [7:0] en_count;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         expQ[$];
  logic [7:0] expCount = 8'd0;

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .START_RUNNING  (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .btn_run (btn_run),
    .btn_step(btn_step),
    .halt_req(halt_req),
    .cpu_en  (cpu_en),
    .running (running),
    .en_count(en_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every enable pulse must match the oldest queued expectation, cycle-exact.
  always @(negedge clk) begin
    if (cpu_en !== 1'b0) begin
      int e;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL cpu_en_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        e = expQ.pop_front();
        if (e != cyc) begin
          failures++;
          $display("[TB] FAIL cpu_en_timing: pulse at cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic step, input int hold,
                               input int after, input bit expectPulse);
    btn_run  = run;
    btn_step = step;
    if (expectPulse) begin
      expQ.push_back(cyc + PRESS_LAT);
      expCount++;
    end
    waitCycles(hold);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    waitCycles(after);
  endtask

  task automatic tickPulse(input bit expectPulse);
    tick = 1'b1;
    if (expectPulse) begin
      expQ.push_back(cyc + 1);
      expCount++;
    end
    waitCycles(10);
    tick = 1'b0;
    waitCycles(10);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick = ~tick;
      waitCycles(1);
    end
    tick = 1'b0;
    rst  = 1'b0;
    waitCycles(1);
    checkOutput("reset_cpu_en", cpu_en, 0);
    checkOutput("reset_running", running, 0);
    checkOutput("reset_en_count", en_count, 0);

    // Ticks while halted must not enable the CPU.
    for (int i = 0; i < 4; i++) tickPulse(1'b0);
    checkOutput("halt_ticks_running", running, 0);
    checkOutput("halt_ticks_en_count", en_count, 0);

    applyStimulus(1'b1, 1'b0, 10, 20, 1'b0);
    checkOutput("run_entered", running, 1);
    for (int i = 0; i < 3; i++) tickPulse(1'b1);
    checkOutput("run_en_count", en_count, int'(expCount));
    checkOutput("run_still_running", running, 1);

    applyStimulus(1'b1, 1'b0, 10, 20, 1'b0);
    checkOutput("run_toggle_halt", running, 0);

    // Bouncing step button: only the final stable level may produce a press.
    for (int i = 0; i < 12; i++) begin
      btn_step = (((i / 2) % 2) == 0);
      waitCycles(1);
    end
    applyStimulus(1'b0, 1'b1, 15, 15, 1'b1);
    checkOutput("bounce_step_running", running, 0);
    checkOutput("bounce_step_en_count", en_count, int'(expCount));

    applyStimulus(1'b1, 1'b0, 10, 20, 1'b0);
    checkOutput("rerun_running", running, 1);
    tick     = 1'b1;
    halt_req = 1'b1;
    waitCycles(1);
    checkOutput("halt_req_running", running, 0);
    halt_req = 1'b0;
    waitCycles(9);
    tick = 1'b0;
    waitCycles(10);
    tickPulse(1'b0);
    tickPulse(1'b0);
    checkOutput("halt_req_en_count", en_count, int'(expCount));
    checkOutput("halt_req_stays_halted", running, 0);

    applyStimulus(1'b1, 1'b1, 10, 20, 1'b0);
    checkOutput("both_buttons_running", running, 1);
    checkOutput("both_buttons_en_count", en_count, int'(expCount));
    applyStimulus(1'b1, 1'b0, 10, 20, 1'b0);
    checkOutput("both_buttons_back_halt", running, 0);

    while (expCount != 8'd255) applyStimulus(1'b0, 1'b1, 8, 8, 1'b1);
    checkOutput("en_count_at_255", en_count, 255);
    applyStimulus(1'b0, 1'b1, 8, 8, 1'b1);
    checkOutput("en_count_wrap", en_count, 0);

    // Reset lands while the step enable is being issued.
    btn_step = 1'b1;
    expQ.push_back(cyc + PRESS_LAT);
    k = 0;
    while (cpu_en !== 1'b1 && k < 20) begin
      waitCycles(1);
      k++;
    end
    checkOutput("step_pulse_before_reset", int'(cpu_en), 1);
    rst      = 1'b1;
    btn_step = 1'b0;
    waitCycles(1);
    checkOutput("rst_in_step_cpu_en", cpu_en, 0);
    checkOutput("rst_in_step_running", running, 0);
    checkOutput("rst_in_step_en_count", en_count, 0);
    waitCycles(2);
    rst      = 1'b0;
    expCount = 8'd0;
    waitCycles(20);
    checkOutput("post_reset_running", running, 0);
    checkOutput("post_reset_en_count", en_count, int'(expCount));

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
